// File: rtl/mdu_core.sv
// Multiply/divide unit for the E stage: owns HI/LO, models a fixed-latency busy window
// and produces the stall request consumed by the hazard unit.
module mdu_core #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_en,
    input  logic [3:0]       mdu_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             start,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } mdu_op_e;

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic             pend_wr_q, pend_wr_d;
    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic                 is_arith, is_mdu;
    logic [2*WIDTH-1:0]   prod_s, prod_u;
    logic                 a_neg, b_neg, b_zero;
    logic [WIDTH-1:0]     abs_a, abs_b, q_mag, r_mag;
    logic [WIDTH-1:0]     q_s, r_s, q_u, r_u;

    always_comb begin
        is_arith  = (mdu_op >= OP_MULT) && (mdu_op <= OP_DIVU);
        is_mdu    = (mdu_op >= OP_MULT) && (mdu_op <= OP_MTLO);
        start     = req_en && is_arith && !busy_q;
        stall_req = req_en && is_mdu && (busy_q || start);
        rd_data   = '0;
        if (mdu_op == OP_MFHI) rd_data = hi_q;
        else if (mdu_op == OP_MFLO) rd_data = lo_q;
    end

    // Signed divide works on magnitudes, so MIN_INT / -1 falls out as MIN_INT rem 0.
    always_comb begin
        prod_s = {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};
        prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
        a_neg  = src_a[WIDTH-1];
        b_neg  = src_b[WIDTH-1];
        b_zero = (src_b == '0);
        abs_a  = a_neg ? -src_a : src_a;
        abs_b  = b_neg ? -src_b : src_b;
        q_mag  = '0;
        r_mag  = '0;
        q_u    = '0;
        r_u    = '0;
        if (!b_zero) begin
            q_mag = abs_a / abs_b;
            r_mag = abs_a % abs_b;
            q_u   = src_a / src_b;
            r_u   = src_a % src_b;
        end
        q_s = (a_neg ^ b_neg) ? -q_mag : q_mag;
        r_s = a_neg ? -r_mag : r_mag;
    end

    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        if (busy_q) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                if (pend_wr_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end
        end else if (req_en) begin
            case (mdu_op_e'(mdu_op))
                OP_MULT: begin
                    {pend_hi_d, pend_lo_d} = prod_s;
                    pend_wr_d = 1'b1;
                    busy_d    = 1'b1;
                    cnt_d     = CW'(MULT_CYCLES);
                end
                OP_MULTU: begin
                    {pend_hi_d, pend_lo_d} = prod_u;
                    pend_wr_d = 1'b1;
                    busy_d    = 1'b1;
                    cnt_d     = CW'(MULT_CYCLES);
                end
                OP_DIV: begin
                    pend_hi_d = r_s;
                    pend_lo_d = q_s;
                    pend_wr_d = !b_zero;
                    busy_d    = 1'b1;
                    cnt_d     = CW'(DIV_CYCLES);
                end
                OP_DIVU: begin
                    pend_hi_d = r_u;
                    pend_lo_d = q_u;
                    pend_wr_d = !b_zero;
                    busy_d    = 1'b1;
                    cnt_d     = CW'(DIV_CYCLES);
                end
                OP_MTHI: hi_d = src_a;
                OP_MTLO: lo_d = src_a;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_core.sv
// Randomized bench for mdu_core against a cycle-level behavioural model of HI/LO and the busy window.
module tb_mdu_core;

    logic        clk;
    logic        reset;
    logic        req_en;
    logic [3:0]  mdu_op;
    logic [31:0] src_a, src_b;
    logic        start, busy, stall_req;
    logic [31:0] rd_data, hi, lo;

    mdu_core #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .req_en(req_en), .mdu_op(mdu_op),
        .src_a(src_a), .src_b(src_b), .start(start), .busy(busy),
        .stall_req(stall_req), .rd_data(rd_data), .hi(hi), .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_total = 0;
    int n_bad   = 0;

    // model state
    logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
    logic        m_pwr = 1'b0;
    int          m_left = 0;

    // last observed DUT values, used by directed sequences
    logic        obs_busy, obs_stall;
    logic [31:0] obs_hi, obs_lo, obs_rd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic en, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] pv, qv, rv;
        if (rst) begin
            m_hi = '0; m_lo = '0; m_left = 0; m_pwr = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pwr) begin
                m_hi = m_phi; m_lo = m_plo;
            end
        end else if (en) begin
            case (op)
                4'd1: begin
                    pv = longint'($signed(a)) * longint'($signed(b));
                    m_phi = pv[63:32]; m_plo = pv[31:0]; m_pwr = 1'b1; m_left = 5;
                end
                4'd2: begin
                    pv = {32'b0, a} * {32'b0, b};
                    m_phi = pv[63:32]; m_plo = pv[31:0]; m_pwr = 1'b1; m_left = 5;
                end
                4'd3: begin
                    m_left = 10;
                    m_pwr  = (b != 0);
                    if (b != 0) begin
                        sa = longint'($signed(a));
                        sb = longint'($signed(b));
                        q = sa / sb; r = sa % sb;
                        qv = q; rv = r;
                        m_plo = qv[31:0]; m_phi = rv[31:0];
                    end
                end
                4'd4: begin
                    m_left = 10;
                    m_pwr  = (b != 0);
                    if (b != 0) begin
                        m_plo = a / b; m_phi = a % b;
                    end
                end
                4'd7: m_hi = a;
                4'd8: m_lo = a;
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        logic        e_busy, e_start, e_stall;
        logic [31:0] e_rd;
        @(negedge clk);
        reset = rst; req_en = en; mdu_op = op; src_a = a; src_b = b;
        #1;
        e_busy  = (m_left > 0);
        e_start = en && op >= 4'd1 && op <= 4'd4 && !e_busy;
        e_stall = en && op >= 4'd1 && op <= 4'd8 && (e_busy || e_start);
        e_rd    = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'h0;
        check("busy", 64'(busy), 64'(e_busy));
        check("start", 64'(start), 64'(e_start));
        check("stall_req", 64'(stall_req), 64'(e_stall));
        check("rd_data", 64'(rd_data), 64'(e_rd));
        check("hi", 64'(hi), 64'(m_hi));
        check("lo", 64'(lo), 64'(m_lo));
        obs_busy = busy; obs_stall = stall_req; obs_hi = hi; obs_lo = lo; obs_rd = rd_data;
        @(posedge clk);
        model_edge(rst, en, op, a, b);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    endtask

    // issue one op, then count idle cycles with busy high (bounded)
    task automatic issue_and_count(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output int n);
        n = 0;
        step(1'b0, 1'b1, op, a, b);
        for (int k = 0; k < 20; k++) begin
            idle();
            if (!obs_busy) break;
            n++;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    int n;

    initial begin
        reset = 1'b1; req_en = 1'b0; mdu_op = '0; src_a = '0; src_b = '0;
        step(1'b1, 1'b0, 4'd0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 4'd1, 32'h5, 32'h5);
        idle();
        check("reset_busy", 64'(obs_busy), 64'd0);
        check("reset_hi", 64'(obs_hi), 64'd0);

        issue_and_count(4'd2, 32'hFFFF_FFFF, 32'd2, n);
        check("multu_cycles", 64'(n), 64'd5);
        check("multu_hi", 64'(obs_hi), 64'h1);
        check("multu_lo", 64'(obs_lo), 64'hFFFF_FFFE);

        step(1'b0, 1'b1, 4'd1, -32'sd3, 32'd7);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, 4'd5, 32'h0, 32'h0);
            if (!obs_stall) break;
            n++;
        end
        check("mfhi_stalls", 64'(n), 64'd5);
        check("mfhi_data", 64'(obs_rd), 64'hFFFF_FFFF);
        check("mult_lo", 64'(obs_lo), 64'hFFFF_FFEB);

        issue_and_count(4'd3, -32'sd7, 32'd2, n);
        check("div_cycles", 64'(n), 64'd10);
        check("div_lo", 64'(obs_lo), 64'hFFFF_FFFD);
        check("div_hi", 64'(obs_hi), 64'hFFFF_FFFF);

        issue_and_count(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
        check("divovf_lo", 64'(obs_lo), 64'h8000_0000);
        check("divovf_hi", 64'(obs_hi), 64'h0);

        step(1'b0, 1'b1, 4'd7, 32'h12, 32'h0);
        step(1'b0, 1'b1, 4'd8, 32'h34, 32'h0);
        issue_and_count(4'd3, 32'd99, 32'd0, n);
        check("div0_cycles", 64'(n), 64'd10);
        check("div0_hi", 64'(obs_hi), 64'h12);
        check("div0_lo", 64'(obs_lo), 64'h34);
        issue_and_count(4'd4, 32'd99, 32'd0, n);
        check("divu0_cycles", 64'(n), 64'd10);
        check("divu0_hi", 64'(obs_hi), 64'h12);
        check("divu0_lo", 64'(obs_lo), 64'h34);

        step(1'b0, 1'b1, 4'd2, 32'd2, 32'd3);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, 4'd7, 32'hAA, 32'h0);
            if (!obs_stall) break;
            n++;
        end
        check("mthi_stalls", 64'(n), 64'd5);
        idle();
        check("mthi_late_hi", 64'(obs_hi), 64'hAA);
        check("mthi_late_lo", 64'(obs_lo), 64'h6);

        step(1'b0, 1'b1, 4'd3, 32'd100, 32'd7);
        idle();
        idle();
        step(1'b1, 1'b0, 4'd0, 32'h0, 32'h0);
        idle();
        check("rstmid_busy", 64'(obs_busy), 64'd0);
        check("rstmid_hi", 64'(obs_hi), 64'd0);
        check("rstmid_lo", 64'(obs_lo), 64'd0);
        for (int k = 0; k < 12; k++) idle();
        check("rstmid_nolate_hi", 64'(obs_hi), 64'd0);
        check("rstmid_nolate_lo", 64'(obs_lo), 64'd0);

        step(1'b0, 1'b0, 4'd1, 32'd5, 32'd5);
        idle();
        check("noen_busy", 64'(obs_busy), 64'd0);

        // back-to-back: next op held until accepted
        step(1'b0, 1'b1, 4'd1, 32'd9, 32'd9);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 4'd4, 32'd100, 32'd9);

        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)),
                 pick(), pick());
        end
        for (int k = 0; k < 12; k++) idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
